mem_port_arbiter: RTL

- Two-requester arbiter and sequencer for the single-port 512x32 system RAM.
- Shares the RAM between the instruction-fetch port (f_*) and the load/store data port (d_*).
- Drives the RAM's read/write/address/data-in lines and returns read data from its registered output (1-cycle read latency) to the granted requester.
- Data port has priority; a starvation counter bounds how long fetch can be locked out.

---
 rtl/mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous RAM (registered output, 1-cycle read
// latency) between an instruction-fetch port (f_*) and a load/store data
// port (d_*). Each access takes three cycles: grant (IDLE -> ACCESS), RAM
// access (ACCESS -> RESP) and response capture (RESP -> IDLE). The data
// port normally wins. A starvation counter tracks consecutive data grants
// taken while a fetch is pending, and hands the RAM to fetch once that
// count reaches STARVE_LIMIT.
//
// Parameters:
//   ADDR_W        RAM address width (512 words by default)
//   DATA_W        RAM word width
//   STARVE_LIMIT  max consecutive data grants while fetch waits (>= 1)
//
// Ports:
//   clock, clear        rising-edge clock, asynchronous active-low reset
//   f_req/f_addr        fetch read request and address (held until f_gnt)
//   f_gnt/f_done        one-cycle accept pulse / read-data-valid pulse
//   f_rdata             last fetched word, held until the next f_done
//   d_req/d_we/d_addr   data request (d_we=1 store, 0 load), held until d_gnt
//   d_wdata             store data
//   d_gnt/d_done        one-cycle accept pulse / completion pulse
//   d_rdata             last load result; stores leave it unchanged
//   ram_read/ram_write  RAM strobes, high only during ACCESS
//   ram_address         RAM address, holds its last value while idle
//   ram_data_in         RAM write data, holds its last value while idle
//   ram_data_out        RAM registered read data
//   busy                high whenever the sequencer is not in IDLE
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic              clock,
  input  logic              clear,

  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_done,
  output logic [DATA_W-1:0] f_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,

  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,

  output logic              busy
);

  // Counter just wide enough to hold 0..STARVE_LIMIT.
  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  // Owner of the access in flight: 1 = data port, 0 = fetch port.
  logic                owner_data_q, owner_data_d;
  // Remembers whether the access in flight is a store. ram_write is cleared
  // on leaving ACCESS, so RESP needs this copy to decide whether to capture
  // read data.
  logic                access_wr_q, access_wr_d;

  logic                f_gnt_q, f_gnt_d;
  logic                f_done_q, f_done_d;
  logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
  logic                d_gnt_q, d_gnt_d;
  logic                d_done_q, d_done_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                ram_read_q, ram_read_d;
  logic                ram_write_q, ram_write_d;
  logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
  logic [DATA_W-1:0]   ram_data_in_q, ram_data_in_d;
  logic                busy_q, busy_d;

  logic                data_wins;
  logic                fetch_starved;

  // Fetch has waited long enough: it takes the next slot even if data asks.
  assign fetch_starved = f_req && (starve_q == LIMIT);
  assign data_wins     = d_req && !fetch_starved;

  // Next-state and next-output logic. Pulses (gnt, done) and RAM strobes
  // default to 0 so they last exactly one cycle; data/address registers
  // default to holding their value.
  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    owner_data_d  = owner_data_q;
    access_wr_d   = access_wr_q;
    f_gnt_d       = 1'b0;
    f_done_d      = 1'b0;
    f_rdata_d     = f_rdata_q;
    d_gnt_d       = 1'b0;
    d_done_d      = 1'b0;
    d_rdata_d     = d_rdata_q;
    ram_read_d    = 1'b0;
    ram_write_d   = 1'b0;
    ram_address_d = ram_address_q;
    ram_data_in_d = ram_data_in_q;

    case (state_q)
      IDLE: begin
        if (data_wins) begin
          d_gnt_d       = 1'b1;
          owner_data_d  = 1'b1;
          access_wr_d   = d_we;
          ram_address_d = d_addr;
          ram_data_in_d = d_wdata;
          ram_write_d   = d_we;
          ram_read_d    = !d_we;
          // Only grants that bypass a waiting fetch count toward starvation.
          if (f_req) begin
            starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + CNT_W'(1);
          end else begin
            starve_d = '0;
          end
          state_d = ACCESS;
        end else if (f_req) begin
          f_gnt_d       = 1'b1;
          owner_data_d  = 1'b0;
          access_wr_d   = 1'b0;
          ram_address_d = f_addr;
          ram_read_d    = 1'b1;
          starve_d      = '0;
          state_d       = ACCESS;
        end
      end

      ACCESS: begin
        // RAM samples address/strobes on this exiting edge.
        state_d = RESP;
      end

      RESP: begin
        // ram_data_out is valid now; a store's incidental read is dropped.
        if (owner_data_q) begin
          d_done_d = 1'b1;
          if (!access_wr_q) begin
            d_rdata_d = ram_data_out;
          end
        end else begin
          f_done_d  = 1'b1;
          f_rdata_d = ram_data_out;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers. Reset abandons any access in flight, so no
  // done pulse follows a mid-operation reset.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q       <= IDLE;
      starve_q      <= '0;
      owner_data_q  <= 1'b0;
      access_wr_q   <= 1'b0;
      f_gnt_q       <= 1'b0;
      f_done_q      <= 1'b0;
      f_rdata_q     <= '0;
      d_gnt_q       <= 1'b0;
      d_done_q      <= 1'b0;
      d_rdata_q     <= '0;
      ram_read_q    <= 1'b0;
      ram_write_q   <= 1'b0;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      owner_data_q  <= owner_data_d;
      access_wr_q   <= access_wr_d;
      f_gnt_q       <= f_gnt_d;
      f_done_q      <= f_done_d;
      f_rdata_q     <= f_rdata_d;
      d_gnt_q       <= d_gnt_d;
      d_done_q      <= d_done_d;
      d_rdata_q     <= d_rdata_d;
      ram_read_q    <= ram_read_d;
      ram_write_q   <= ram_write_d;
      ram_address_q <= ram_address_d;
      ram_data_in_q <= ram_data_in_d;
      busy_q        <= busy_d;
    end
  end

  assign f_gnt       = f_gnt_q;
  assign f_done      = f_done_q;
  assign f_rdata     = f_rdata_q;
  assign d_gnt       = d_gnt_q;
  assign d_done      = d_done_q;
  assign d_rdata     = d_rdata_q;
  assign ram_read    = ram_read_q;
  assign ram_write   = ram_write_q;
  assign ram_address = ram_address_q;
  assign ram_data_in = ram_data_in_q;
  assign busy        = busy_q;

endmodule
